run_sequencer: RTL and testbench
================================

# run_sequencer

Host-side run controller for the counter model's `clk`/`reset_l`/`stop`/`done` interface. It drives the model's reset and stop-value inputs, monitors its `done` output, and counts run cycles until completion. It also enforces an optional cycle-limit timeout and reports the outcome to the SST-facing wrapper. It sits between the SST component glue and one counter instance, on the same clock.

## Interface
Parameters:
- `INPUT_WIDTH`, 32, width of the stop value driven to the model
- `CYCLE_WIDTH`, 32, width of the cycle counter and timeout limit
- `RESET_CYCLES`, 4, number of clocks the model is held in reset before a run (legal range ≥1)

Ports:
- `clk` input 1: single clock, shared with the model
- `reset_l` input 1: reset is asynchronous and active-low
- `start` input 1: begin a run (single-cycle pulse)
- `abort` input 1: cancel any run and return to idle
- `stop_value` input INPUT_WIDTH: stop value, sampled on an accepted `start`
- `limit` input CYCLE_WIDTH: timeout in RUN cycles, sampled on an accepted `start`; 0 disables the timeout
- `dut_reset_l` output 1: registered reset to the model
- `dut_stop` output INPUT_WIDTH: registered stop value to the model
- `dut_done` input 1: the model's `done`
- `busy` output 1: high in RESET and RUN
- `run_done` output 1: sticky, set when the run completed
- `run_timeout` output 1: sticky, set when the run timed out
- `cycles` output CYCLE_WIDTH: final RUN-cycle count of the last run

## Operation
- Reset values for all outputs: `dut_reset_l`=0, `dut_stop`=0, `busy`=0, `run_done`=0, `run_timeout`=0, `cycles`=0. The state is IDLE.
- States: IDLE, RESET, RUN, DONE, TIMEOUT.
- `dut_reset_l` is 1 only in RUN. In all other states, including DONE and TIMEOUT, the model is held in reset.
- IDLE/DONE/TIMEOUT with `start`=1:
  - latch `stop_value`→`dut_stop` and `limit`
  - clear `run_done`, `run_timeout`, `cycles`
  - load the reset counter with RESET_CYCLES-1
  - go to RESET
- RESET: decrement the reset counter each cycle. At 0, go to RUN with the run counter k=0. RESET therefore lasts exactly RESET_CYCLES cycles.
- RUN, evaluated each cycle at count k:
  - if `dut_done`=1: `cycles`←k, `run_done`←1, go to DONE
  - else if `limit`≠0 and k+1==`limit`: `cycles`←`limit`, `run_timeout`←1, go to TIMEOUT
  - else k←k+1; k saturates at all-ones and RUN continues
- `dut_done` and timeout in the same cycle: done wins.
- `start` in RESET or RUN is ignored.
- `abort`=1 in any state: go to IDLE next cycle, `dut_reset_l`←0, `busy`←0. Sticky flags and `cycles` are cleared.
- `abort` and `start` in the same cycle: abort wins.
- `dut_done` is ignored outside RUN. The model's `done` is combinational and is valid during its reset.
- Asynchronous `reset_l` assertion mid-run: all outputs take their reset values immediately. `dut_reset_l` drops asynchronously.

## Timing
- `start` sampled at edge N: `busy`=1 and `dut_reset_l`=0 from N+1.
- RUN begins at N+1+RESET_CYCLES. The model's counter equals its START value in RUN cycle k=0 and START+k in cycle k.
- Run length: with START=10 and stop S≥10, `run_done` rises at the edge ending RUN cycle S-10, with `cycles`=S-10.
- Completion edge: `dut_reset_l`, `busy`→0 and the sticky flag→1 all update on the same edge.
- Latency from `dut_done` high to `run_done`: 1 clock.
- Timeout: with `limit`=L≠0, `run_timeout` rises at the edge ending RUN cycle L-1.
- Stop values below START: the model wraps at 2^INPUT_WIDTH. Only the timeout, or an abort when `limit`=0, terminates the run.

## Test plan
- Reset with `start` held high → all outputs 0 and state IDLE. After `reset_l` deasserts, one `start` begins a run.
- `stop_value`=15, `limit`=0, START=10 → `dut_reset_l` low for 4 cycles, then `run_done`=1 and `cycles`=5, `busy` high for 4+6 cycles.
- `stop_value`=10 → `run_done` after RUN cycle 0, `cycles`=0.
- `stop_value`=5, `limit`=20 → `run_timeout`=1, `cycles`=20, `run_done`=0. Also `stop_value`=29, `limit`=20 (done and timeout in the same cycle, k=19) → `run_done`=1, `cycles`=19.
- `abort` in the 3rd RUN cycle → IDLE next cycle, `dut_reset_l`=0 and flags 0. A `start` during RUN is ignored, verified by unchanged `dut_stop`.
- Async `reset_l` low mid-RUN, between edges → `dut_reset_l` and `busy` drop before the next edge. A restart from DONE with a new `stop_value` reruns correctly.

Source files
------------

// File: rtl/run_sequencer.sv
// Host-side run controller: holds a counter model in reset, releases it for a run,
// counts RUN cycles until the model reports done or the optional cycle limit expires.
module run_sequencer #(
  parameter int INPUT_WIDTH  = 32,
  parameter int CYCLE_WIDTH  = 32,
  parameter int RESET_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   start,
  input  logic                   abort,
  input  logic [INPUT_WIDTH-1:0] stop_value,
  input  logic [CYCLE_WIDTH-1:0] limit,
  output logic                   dut_reset_l,
  output logic [INPUT_WIDTH-1:0] dut_stop,
  input  logic                   dut_done,
  output logic                   busy,
  output logic                   run_done,
  output logic                   run_timeout,
  output logic [CYCLE_WIDTH-1:0] cycles
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t                 r_state, w_state;
  logic [RW-1:0]          r_rst_cnt, w_rst_cnt;
  logic [CYCLE_WIDTH-1:0] r_run_cnt, w_run_cnt;
  logic [CYCLE_WIDTH-1:0] r_limit, w_limit;
  logic [INPUT_WIDTH-1:0] r_dut_stop, w_dut_stop;
  logic                   r_dut_reset_l, w_dut_reset_l;
  logic                   r_busy, w_busy;
  logic                   r_run_done, w_run_done;
  logic                   r_run_timeout, w_run_timeout;
  logic [CYCLE_WIDTH-1:0] r_cycles, w_cycles;
  logic                   w_limit_hit;

  // Timeout fires when the cycle being evaluated is the last one allowed by the limit.
  assign w_limit_hit = (r_limit != '0) && (r_run_cnt == r_limit - CYCLE_WIDTH'(1));

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_state       = r_state;
    w_rst_cnt     = r_rst_cnt;
    w_run_cnt     = r_run_cnt;
    w_limit       = r_limit;
    w_dut_stop    = r_dut_stop;
    w_run_done    = r_run_done;
    w_run_timeout = r_run_timeout;
    w_cycles      = r_cycles;

    if (abort) begin
      w_state       = S_IDLE;
      w_run_done    = 1'b0;
      w_run_timeout = 1'b0;
      w_cycles      = '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (start) begin
            w_state       = S_RESET;
            w_dut_stop    = stop_value;
            w_limit       = limit;
            w_run_done    = 1'b0;
            w_run_timeout = 1'b0;
            w_cycles      = '0;
            w_rst_cnt     = RW'(RESET_CYCLES - 1);
          end
        end
        S_RESET: begin
          if (r_rst_cnt == '0) begin
            w_state   = S_RUN;
            w_run_cnt = '0;
          end else begin
            w_rst_cnt = r_rst_cnt - RW'(1);
          end
        end
        S_RUN: begin
          if (dut_done) begin
            w_state    = S_DONE;
            w_cycles   = r_run_cnt;
            w_run_done = 1'b1;
          end else if (w_limit_hit) begin
            w_state       = S_TIMEOUT;
            w_cycles      = r_limit;
            w_run_timeout = 1'b1;
          end else if (r_run_cnt != '1) begin
            w_run_cnt = r_run_cnt + CYCLE_WIDTH'(1);
          end
        end
        default: w_state = S_IDLE;
      endcase
    end

    // Outputs are registered from the next state so they change on the transition edge.
    w_dut_reset_l = (w_state == S_RUN);
    w_busy        = (w_state == S_RESET) || (w_state == S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state       <= S_IDLE;
      r_rst_cnt     <= '0;
      r_run_cnt     <= '0;
      r_limit       <= '0;
      r_dut_stop    <= '0;
      r_dut_reset_l <= 1'b0;
      r_busy        <= 1'b0;
      r_run_done    <= 1'b0;
      r_run_timeout <= 1'b0;
      r_cycles      <= '0;
    end else begin
      r_state       <= w_state;
      r_rst_cnt     <= w_rst_cnt;
      r_run_cnt     <= w_run_cnt;
      r_limit       <= w_limit;
      r_dut_stop    <= w_dut_stop;
      r_dut_reset_l <= w_dut_reset_l;
      r_busy        <= w_busy;
      r_run_done    <= w_run_done;
      r_run_timeout <= w_run_timeout;
      r_cycles      <= w_cycles;
    end
  end

  assign dut_reset_l = r_dut_reset_l;
  assign dut_stop    = r_dut_stop;
  assign busy        = r_busy;
  assign run_done    = r_run_done;
  assign run_timeout = r_run_timeout;
  assign cycles      = r_cycles;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer with a counter model (START=10) and an
// outcome predictor computed arithmetically from stop value and limit.
module tb_run_sequencer;

  localparam int IW = 32;
  localparam int CW = 32;
  localparam int RC = 4;
  localparam logic [IW-1:0] START = 10;

  logic          clk;
  logic          reset_l;
  logic          start;
  logic          abort;
  logic [IW-1:0] stop_value;
  logic [CW-1:0] limit;
  logic          dut_reset_l;
  logic [IW-1:0] dut_stop;
  logic          dut_done;
  logic          busy;
  logic          run_done;
  logic          run_timeout;
  logic [CW-1:0] cycles;

  run_sequencer #(
    .INPUT_WIDTH (IW),
    .CYCLE_WIDTH (CW),
    .RESET_CYCLES(RC)
  ) u_dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .start      (start),
    .abort      (abort),
    .stop_value (stop_value),
    .limit      (limit),
    .dut_reset_l(dut_reset_l),
    .dut_stop   (dut_stop),
    .dut_done   (dut_done),
    .busy       (busy),
    .run_done   (run_done),
    .run_timeout(run_timeout),
    .cycles     (cycles)
  );

  // Counter model: reloads START while held in reset, counts up otherwise.
  logic [IW-1:0] m_count;
  always_ff @(posedge clk) begin
    if (!dut_reset_l) m_count <= START;
    else              m_count <= m_count + 1'b1;
  end
  assign dut_done = (m_count == dut_stop);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outcome from the rules: done at k = S-START (wrapping if S<START), timeout at k = L-1.
  function automatic void predict(input longint s, input longint l,
                                  output longint kend, output bit done_wins,
                                  output longint cyc);
    longint kd;
    kd = (s >= START) ? s - START : (longint'(1) << IW) - START + s;
    if (l != 0 && (l - 1) < kd) begin
      kend = l - 1; done_wins = 1'b0; cyc = l;
    end else begin
      kend = kd; done_wins = 1'b1; cyc = kd;
    end
  endfunction

  task automatic do_run(input logic [IW-1:0] s, input logic [CW-1:0] l,
                        input bit poke, input string tag);
    int busy_cnt, rst_cnt, guard;
    bit poked;
    longint kend, cyc;
    bit done_wins;
    busy_cnt = 0; rst_cnt = 0; guard = 0; poked = 1'b0;
    @(negedge clk);
    stop_value = s; limit = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    check({tag, "_hold_rst"}, dut_reset_l, 0);
    while (busy && guard < 5000) begin
      busy_cnt++;
      if (!dut_reset_l) rst_cnt++;
      guard++;
      if (poke && dut_reset_l && !poked) begin
        start = 1'b1; stop_value = ~s; poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    predict(longint'(s), longint'(l), kend, done_wins, cyc);
    check({tag, "_ended"}, busy, 0);
    check({tag, "_busy_len"}, busy_cnt, RC + kend + 1);
    check({tag, "_rst_len"}, rst_cnt, RC);
    check({tag, "_run_done"}, run_done, done_wins);
    check({tag, "_run_timeout"}, run_timeout, !done_wins);
    check({tag, "_cycles"}, cycles, cyc);
    check({tag, "_dut_rst_after"}, dut_reset_l, 0);
    check({tag, "_dut_stop"}, dut_stop, s);
  endtask

  // Starts an unbounded run and returns at the negedge inside RUN cycle n (0-based).
  task automatic run_until(input int n, input string tag);
    int seen, guard;
    seen = 0; guard = 0;
    @(negedge clk);
    stop_value = 200; limit = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (guard < 100) begin
      if (dut_reset_l) begin
        if (seen == n) break;
        seen++;
      end
      guard++;
      @(negedge clk);
    end
    check({tag, "_reached_run"}, dut_reset_l, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_l = 1'b0; start = 1'b1; abort = 1'b0; stop_value = 32'd77; limit = 0;
    repeat (3) @(negedge clk);
    check("rst_dut_reset_l", dut_reset_l, 0);
    check("rst_dut_stop", dut_stop, 0);
    check("rst_busy", busy, 0);
    check("rst_run_done", run_done, 0);
    check("rst_run_timeout", run_timeout, 0);
    check("rst_cycles", cycles, 0);
    start = 1'b0;
    reset_l = 1'b1;
    @(negedge clk);
    check("idle_after_rst", busy, 0);

    do_run(15, 0, 1'b0, "s15");
    do_run(10, 0, 1'b0, "s10");
    do_run(5, 20, 1'b0, "s5_l20");
    do_run(29, 20, 1'b0, "s29_l20");
    do_run(30, 20, 1'b0, "s30_l20");
    do_run(12, 1, 1'b0, "s12_l1");
    do_run(23, 0, 1'b1, "poke");

    // Abort in the third RUN cycle.
    run_until(2, "abort");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_dut_rst", dut_reset_l, 0);
    check("abort_done", run_done, 0);
    check("abort_timeout", run_timeout, 0);
    check("abort_cycles", cycles, 0);

    // Abort from DONE clears the sticky flag; abort beats start.
    do_run(18, 0, 1'b0, "pre_abort");
    @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_done_flag", run_done, 0);
    check("abort_done_cycles", cycles, 0);
    check("abort_beats_start", busy, 0);

    // Asynchronous reset between edges mid-RUN.
    run_until(3, "async");
    #2 reset_l = 1'b0;
    #1;
    check("async_dut_rst", dut_reset_l, 0);
    check("async_busy", busy, 0);
    check("async_dut_stop", dut_stop, 0);
    @(negedge clk);
    reset_l = 1'b1;
    do_run(16, 0, 1'b0, "restart");
    do_run(21, 0, 1'b0, "restart_done");

    for (int i = 0; i < 20; i++) begin
      logic [IW-1:0] s;
      logic [CW-1:0] l;
      if ($urandom_range(0, 3) == 0) begin
        s = $urandom_range(0, 9);
        l = $urandom_range(1, 40);
      end else begin
        s = $urandom_range(10, 60);
        l = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 60);
      end
      do_run(s, l, $urandom_range(0, 3) == 0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
